kbd_decoder: RTL

PS/2 set-2 scancode to ASCII translator, parametrised successor of the fixed 128x14 keyboard lookup ROM. It parses make, break and extended prefixes with a state machine, tracks Shift, Ctrl and Caps-Lock, and looks up a synchronous 128-entry table. Translated characters go into a first-word-fall-through FIFO with a valid/ready output. It sits between the PS/2 byte receiver and the VGA text/terminal logic.

---
 rtl/kbd_pkg.sv | 95 +++++++++
 rtl/kbd_fifo.sv | 65 ++++++
 rtl/kbd_decoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types, scancode constants and the built-in set-2 to ASCII map for kbd_decoder.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] LETTER_LO = 8'h41;
  localparam logic [7:0] LETTER_HI = 8'h5A;
  localparam logic [7:0] CTRL_LO   = 8'h40;
  localparam logic [7:0] CTRL_HI   = 8'h7F;
  localparam logic [7:0] CTRL_MASK = 8'h1F;

  localparam int unsigned ADDR_W = 7;

  // Lookup request, modifiers captured at the time of the make code
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              shift;
    logic              ctrl;
    logic              caps;
  } kbd_req_t;

  function automatic logic is_modifier(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
           (code == SC_CTRL)   || (code == SC_CAPS);
  endfunction

  // Same contents as kbdrom.mem: {primary[13:7], alternate[6:0]}; zero = unmapped
  function automatic logic [13:0] kbd_map(input logic [ADDR_W-1:0] code);
    logic [13:0] w;
    case (code)
      7'h1C: w = {7'h41, 7'h61};
      7'h32: w = {7'h42, 7'h62};
      7'h21: w = {7'h43, 7'h63};
      7'h23: w = {7'h44, 7'h64};
      7'h24: w = {7'h45, 7'h65};
      7'h2B: w = {7'h46, 7'h66};
      7'h34: w = {7'h47, 7'h67};
      7'h33: w = {7'h48, 7'h68};
      7'h43: w = {7'h49, 7'h69};
      7'h3B: w = {7'h4A, 7'h6A};
      7'h42: w = {7'h4B, 7'h6B};
      7'h4B: w = {7'h4C, 7'h6C};
      7'h3A: w = {7'h4D, 7'h6D};
      7'h31: w = {7'h4E, 7'h6E};
      7'h44: w = {7'h4F, 7'h6F};
      7'h4D: w = {7'h50, 7'h70};
      7'h15: w = {7'h51, 7'h71};
      7'h2D: w = {7'h52, 7'h72};
      7'h1B: w = {7'h53, 7'h73};
      7'h2C: w = {7'h54, 7'h74};
      7'h3C: w = {7'h55, 7'h75};
      7'h2A: w = {7'h56, 7'h76};
      7'h1D: w = {7'h57, 7'h77};
      7'h22: w = {7'h58, 7'h78};
      7'h35: w = {7'h59, 7'h79};
      7'h1A: w = {7'h5A, 7'h7A};
      7'h16: w = {7'h31, 7'h21};
      7'h1E: w = {7'h32, 7'h40};
      7'h26: w = {7'h33, 7'h23};
      7'h25: w = {7'h34, 7'h24};
      7'h2E: w = {7'h35, 7'h25};
      7'h36: w = {7'h36, 7'h5E};
      7'h3D: w = {7'h37, 7'h26};
      7'h3E: w = {7'h38, 7'h2A};
      7'h46: w = {7'h39, 7'h28};
      7'h45: w = {7'h30, 7'h29};
      7'h4E: w = {7'h2D, 7'h5F};
      7'h55: w = {7'h3D, 7'h2B};
      7'h41: w = {7'h2C, 7'h3C};
      7'h49: w = {7'h2E, 7'h3E};
      7'h4A: w = {7'h2F, 7'h3F};
      7'h29: w = {7'h20, 7'h20};
      7'h5A: w = {7'h0D, 7'h0D};
      7'h66: w = {7'h08, 7'h08};
      7'h0D: w = {7'h09, 7'h09};
      7'h76: w = {7'h1B, 7'h1B};
      default: w = 14'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through FIFO with registered head/valid and a sticky overflow flag.
module kbd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          full_c, pop_c, push_c;
  logic [W-1:0]  head_c;

  always_comb begin
    full_c = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_c  = valid_q && rd_ready;
    push_c = wr_en && (!full_c || pop_c);
    rd_d   = rd_q + PW'(pop_c);
    wr_d   = wr_q + PW'(push_c);
    // A word written into the slot that becomes the head bypasses the array
    if (push_c && (rd_d[AW-1:0] == wr_q[AW-1:0])) head_c = wr_data;
    else                                          head_c = mem_q[rd_d[AW-1:0]];
    valid_d = (wr_d != rd_d);
    data_d  = valid_d ? head_c : data_q;
    ovf_d   = ovf_q || (wr_en && full_c && !pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 set-2 scancode parser with modifier tracking, synchronous ROM lookup and FWFT output FIFO.
module kbd_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CHAR_W     = 7,
  parameter string       TABLE_FILE = "kbdrom.mem",
  parameter bit          CAPS_INIT  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  output logic       caps_led,
  output logic       overflow
);

  // The built-in image mirrors kbdrom.mem; an empty name leaves every entry unmapped.
  // CHAR_W is expected in 7..8 so a character fits the 8-bit selection path.
  localparam bit TABLE_EN = (TABLE_FILE != "");

  kbd_state_e state_q, state_d;
  logic shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic ctrl_q, ctrl_d, caps_held_q, caps_held_d, caps_led_q, caps_led_d;
  kbd_req_t req_q, req_d;

  logic                  lk_valid_q, lk_valid_d;
  logic [2*CHAR_W-1:0]   lk_word_q, lk_word_d;
  logic                  lk_shift_q, lk_shift_d, lk_ctrl_q, lk_ctrl_d, lk_caps_q, lk_caps_d;

  logic                  make_c, break_c, ext_c, prefix_c;
  logic [13:0]           map_c;
  logic [CHAR_W-1:0]     primary_c, alt_c;
  logic                  letter_c, use_alt_c;
  logic [7:0]            ch_c;
  logic                  fifo_wr_c;
  logic [7:0]            fifo_data_c;

  // Parser, modifier tracking and lookup request
  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    ctrl_d      = ctrl_q;
    caps_held_d = caps_held_q;
    caps_led_d  = caps_led_q;
    req_d       = '0;
    make_c      = 1'b0;
    break_c     = 1'b0;
    ext_c       = 1'b0;
    prefix_c    = (scan_code == SC_BREAK) || (scan_code == SC_EXT);

    if (scan_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)    state_d = ST_BRK;
          else if (scan_code == SC_EXT) state_d = ST_EXT;
          else                          make_c  = 1'b1;
        end
        ST_BRK: begin
          if (!prefix_c) begin
            break_c = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            make_c  = 1'b1;
            ext_c   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (!prefix_c) begin
            break_c = 1'b1;
            ext_c   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (make_c || break_c) begin
      case (scan_code)
        SC_LSHIFT: shift_l_d = make_c;
        SC_RSHIFT: shift_r_d = make_c;
        SC_CTRL:   ctrl_d    = make_c;
        SC_CAPS: begin
          // Typematic repeats of Caps-Lock must not toggle again
          if (make_c && !caps_held_q) caps_led_d = !caps_led_q;
          caps_held_d = make_c;
        end
        default: ;
      endcase
    end

    if (make_c && !ext_c && !is_modifier(scan_code) && !scan_code[7]) begin
      req_d.valid = 1'b1;
      req_d.addr  = scan_code[ADDR_W-1:0];
      req_d.shift = shift_l_q || shift_r_q;
      req_d.ctrl  = ctrl_q;
      req_d.caps  = caps_led_q;
    end
  end

  // Synchronous table read
  always_comb begin
    map_c      = kbd_map(req_q.addr);
    lk_valid_d = req_q.valid;
    lk_word_d  = TABLE_EN ? {CHAR_W'(map_c[13:7]), CHAR_W'(map_c[6:0])} : '0;
    lk_shift_d = req_q.shift;
    lk_ctrl_d  = req_q.ctrl;
    lk_caps_d  = req_q.caps;
  end

  // Character selection feeding the FIFO write port
  always_comb begin
    primary_c = lk_word_q[2*CHAR_W-1:CHAR_W];
    alt_c     = lk_word_q[CHAR_W-1:0];
    letter_c  = (8'(primary_c) >= LETTER_LO) && (8'(primary_c) <= LETTER_HI);
    use_alt_c = lk_shift_q ^ (lk_caps_q && letter_c);
    ch_c      = use_alt_c ? 8'(alt_c) : 8'(primary_c);
    if (lk_ctrl_q && (ch_c >= CTRL_LO) && (ch_c <= CTRL_HI)) ch_c = ch_c & CTRL_MASK;
    fifo_wr_c   = lk_valid_q && (ch_c != 8'h00);
    fifo_data_c = {1'b0, ch_c[6:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_held_q <= 1'b0;
      caps_led_q  <= CAPS_INIT;
      req_q       <= '0;
      lk_valid_q  <= 1'b0;
      lk_word_q   <= '0;
      lk_shift_q  <= 1'b0;
      lk_ctrl_q   <= 1'b0;
      lk_caps_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      ctrl_q      <= ctrl_d;
      caps_held_q <= caps_held_d;
      caps_led_q  <= caps_led_d;
      req_q       <= req_d;
      lk_valid_q  <= lk_valid_d;
      lk_word_q   <= lk_word_d;
      lk_shift_q  <= lk_shift_d;
      lk_ctrl_q   <= lk_ctrl_d;
      lk_caps_q   <= lk_caps_d;
    end
  end

  kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (fifo_wr_c),
    .wr_data   (fifo_data_c),
    .rd_ready  (out_ready),
    .out_valid (out_valid),
    .out_data  (out_char),
    .overflow  (overflow)
  );

  assign caps_led = caps_led_q;

endmodule
